// File: rtl/pixel_depth_writer.sv
// Depth-tested pixel writer: queues rasterizer pixels, tests them against a 2-bit
// depth RAM, and hands survivors to the framebuffer over a req/ack handshake.
module pixel_depth_writer #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_sig_write_pixel,
  input  logic        in_sig_rasterize_done,
  input  logic [15:0] in_pixel_x,
  input  logic [15:0] in_pixel_y,
  input  logic [1:0]  in_pixel_depth,
  input  logic [15:0] in_pixel_color,
  input  logic        in_sig_clear_depth,
  output logic        out_fb_write_req,
  output logic [14:0] out_fb_addr,
  output logic [15:0] out_fb_data,
  input  logic        in_fb_write_ack,
  output logic        out_sig_busy,
  output logic        out_sig_overflow,
  output logic        out_sig_frame_done,
  output logic [15:0] out_pixels_written,
  output logic [15:0] out_pixels_culled
);

  localparam int AW   = 15;
  localparam int NPIX = SCREEN_W * SCREEN_H;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] W16 = 16'(SCREEN_W);
  localparam logic [15:0] H16 = 16'(SCREEN_H);

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  depth;
    logic [15:0] color;
  } pix_t;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_TEST, S_WRITE, S_CLEAR} state_t;

  state_t        state_q, state_d;
  pix_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic [1:0]    depth_mem [NPIX];
  logic [1:0]    rd_depth_q;
  logic [AW-1:0] cur_addr_q, clr_cnt_q;
  logic [15:0]   cur_color_q;
  logic [1:0]    cur_depth_q;
  logic          cur_oob_q;
  logic          clr_pend_q, done_q, overflow_q;
  logic [15:0]   written_q, culled_q;

  logic          fifo_empty, fifo_full, push, pop, cull, wr_done, frame_done;
  pix_t          head;
  logic          head_oob;
  logic [AW-1:0] head_addr;
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [1:0]    ram_wd;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop        = (state_q == S_IDLE) && !clr_pend_q && !fifo_empty;
  assign push       = in_sig_write_pixel && (!fifo_full || pop);
  assign head       = fifo_mem[rd_ptr_q];
  assign head_oob   = (head.x >= W16) || (head.y >= H16);
  assign head_addr  = AW'(32'(head.y) * 32'(SCREEN_W) + 32'(head.x));

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= '{in_pixel_x, in_pixel_y, in_pixel_depth, in_pixel_color};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Single write port shared by the clear sweep and accepted pixel writes.
  assign ram_we = !reset && ((state_q == S_CLEAR) || wr_done);
  assign ram_wa = (state_q == S_CLEAR) ? clr_cnt_q : cur_addr_q;
  assign ram_wd = (state_q == S_CLEAR) ? 2'd3 : cur_depth_q;

  always_ff @(posedge clock) begin
    if (ram_we) depth_mem[ram_wa] <= ram_wd;
    if (pop && !head_oob) rd_depth_q <= depth_mem[head_addr];
  end

  always_comb begin
    state_d = state_q;
    cull    = 1'b0;
    wr_done = 1'b0;
    case (state_q)
      S_IDLE:  if (clr_pend_q) state_d = S_CLEAR;
               else if (!fifo_empty) state_d = S_FETCH;
      S_FETCH: state_d = S_TEST;
      S_TEST: begin
        if (cur_oob_q || (cur_depth_q > rd_depth_q)) begin
          cull    = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: if (in_fb_write_ack) begin
        wr_done = 1'b1;
        state_d = S_IDLE;
      end
      S_CLEAR: if (clr_cnt_q == AW'(NPIX - 1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign frame_done = done_q && fifo_empty && (state_q == S_IDLE) && !clr_pend_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      cur_color_q <= '0;
      cur_depth_q <= '0;
      cur_oob_q   <= 1'b0;
      clr_cnt_q   <= '0;
      clr_pend_q  <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      written_q   <= '0;
      culled_q    <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        cur_addr_q  <= head_addr;
        cur_color_q <= head.color;
        cur_depth_q <= head.depth;
        cur_oob_q   <= head_oob;
      end
      clr_cnt_q <= (state_q == S_CLEAR) ? clr_cnt_q + 1'b1 : '0;
      if (in_sig_clear_depth) clr_pend_q <= 1'b1;
      else if (state_q == S_IDLE && clr_pend_q) clr_pend_q <= 1'b0;
      if (in_sig_rasterize_done) done_q <= 1'b1;
      else if (frame_done) done_q <= 1'b0;
      if (in_sig_write_pixel && !push) overflow_q <= 1'b1;
      if (wr_done) written_q <= written_q + 1'b1;
      if (cull)    culled_q  <= culled_q + 1'b1;
    end
  end

  assign out_fb_write_req   = (state_q == S_WRITE);
  assign out_fb_addr        = cur_addr_q;
  assign out_fb_data        = cur_color_q;
  assign out_sig_busy       = (state_q != S_IDLE) || !fifo_empty;
  assign out_sig_overflow   = overflow_q;
  assign out_sig_frame_done = frame_done;
  assign out_pixels_written = written_q;
  assign out_pixels_culled  = culled_q;

endmodule

// File: tb/tb_pixel_depth_writer.sv
// Directed bench for pixel_depth_writer: clear, depth test, culling, overflow,
// frame-done and mid-handshake reset, with hand-computed expectations.
module tb_pixel_depth_writer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_sig_write_pixel = 1'b0, in_sig_rasterize_done = 1'b0;
  logic [15:0] in_pixel_x = '0, in_pixel_y = '0, in_pixel_color = '0;
  logic [1:0]  in_pixel_depth = '0;
  logic        in_sig_clear_depth = 1'b0, in_fb_write_ack = 1'b0;
  logic        out_fb_write_req, out_sig_busy, out_sig_overflow, out_sig_frame_done;
  logic [14:0] out_fb_addr;
  logic [15:0] out_fb_data, out_pixels_written, out_pixels_culled;
  int total = 0, bad = 0;

  pixel_depth_writer dut (
    .clock(clock), .reset(reset),
    .in_sig_write_pixel(in_sig_write_pixel), .in_sig_rasterize_done(in_sig_rasterize_done),
    .in_pixel_x(in_pixel_x), .in_pixel_y(in_pixel_y), .in_pixel_depth(in_pixel_depth),
    .in_pixel_color(in_pixel_color), .in_sig_clear_depth(in_sig_clear_depth),
    .out_fb_write_req(out_fb_write_req), .out_fb_addr(out_fb_addr), .out_fb_data(out_fb_data),
    .in_fb_write_ack(in_fb_write_ack), .out_sig_busy(out_sig_busy),
    .out_sig_overflow(out_sig_overflow), .out_sig_frame_done(out_sig_frame_done),
    .out_pixels_written(out_pixels_written), .out_pixels_culled(out_pixels_culled)
  );

  always #5 clock = ~clock;

  // Stimulus helpers only; every check is done by the calling test.
  task automatic drive_px(input int x, input int y, input int d, input int c);
    in_sig_write_pixel = 1'b1;
    in_pixel_x = 16'(x); in_pixel_y = 16'(y); in_pixel_depth = 2'(d); in_pixel_color = 16'(c);
  endtask

  task automatic push_px(input int x, input int y, input int d, input int c);
    drive_px(x, y, d, c);
    @(negedge clock);
    in_sig_write_pixel = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_fb_write_req) begin ok = 1'b1; break; end
      @(negedge clock);
    end
  endtask

  task automatic ack_once();
    in_fb_write_ack = 1'b1;
    @(negedge clock);
    in_fb_write_ack = 1'b0;
  endtask

  task automatic watch(input int n, output int reqs);
    reqs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (out_fb_write_req) reqs++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (out_fb_write_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", out_fb_write_req); end
    total++; if (out_sig_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", out_sig_busy); end
    total++; if ({out_sig_overflow, out_sig_frame_done} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", out_sig_overflow, out_sig_frame_done); end
    total++; if ({out_pixels_written, out_pixels_culled} !== 32'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", out_pixels_written, out_pixels_culled); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_clear();
    bit done;
    in_sig_clear_depth = 1'b1;
    @(negedge clock);
    in_sig_clear_depth = 1'b0;
    @(negedge clock);
    total++; if (out_sig_busy !== 1'b1) begin bad++; $display("FAIL clear_busy got=%b exp=1", out_sig_busy); end
    done = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clock);
      if (!out_sig_busy) begin done = 1'b1; break; end
    end
    total++; if (!done) begin bad++; $display("FAIL clear_timeout got=busy exp=idle"); end
  endtask

  task automatic test_basic();
    drive_px(100, 25, 1, 16'hFF00);
    @(negedge clock);
    in_sig_write_pixel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_fb_write_req !== 1'b0) begin bad++; $display("FAIL basic_early_req cyc=%0d got=1 exp=0", i); end
      @(negedge clock);
    end
    total++; if (out_fb_write_req !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b exp=1", out_fb_write_req); end
    total++; if (out_fb_addr !== 15'd4100) begin bad++; $display("FAIL basic_addr got=%0d exp=4100", out_fb_addr); end
    total++; if (out_fb_data !== 16'hFF00) begin bad++; $display("FAIL basic_data got=%h exp=ff00", out_fb_data); end
    repeat (2) @(negedge clock);
    total++; if (out_fb_write_req !== 1'b1 || out_fb_addr !== 15'd4100) begin bad++; $display("FAIL basic_hold got=%b/%0d exp=1/4100", out_fb_write_req, out_fb_addr); end
    ack_once();
    total++; if (out_pixels_written !== 16'd1) begin bad++; $display("FAIL basic_written got=%0d exp=1", out_pixels_written); end
    total++; if (out_fb_write_req !== 1'b0) begin bad++; $display("FAIL basic_req_drop got=1 exp=0"); end
  endtask

  task automatic test_depth();
    int reqs; bit ok;
    push_px(100, 25, 2, 16'h1111);
    watch(8, reqs);
    total++; if (reqs !== 0) begin bad++; $display("FAIL depth_fail_req got=%0d exp=0", reqs); end
    total++; if (out_pixels_culled !== 16'd1) begin bad++; $display("FAIL depth_culled got=%0d exp=1", out_pixels_culled); end
    push_px(100, 25, 0, 16'h2222);
    wait_req(ok);
    total++; if (!ok || out_fb_addr !== 15'd4100 || out_fb_data !== 16'h2222) begin bad++; $display("FAIL depth_pass got=%b/%0d/%h exp=1/4100/2222", ok, out_fb_addr, out_fb_data); end
    ack_once();
    total++; if (out_pixels_written !== 16'd2) begin bad++; $display("FAIL depth_written got=%0d exp=2", out_pixels_written); end
  endtask

  task automatic test_offscreen();
    int reqs; bit ok;
    push_px(170, 25, 0, 16'h1234);
    watch(8, reqs);
    total++; if (reqs !== 0) begin bad++; $display("FAIL offscreen_req got=%0d exp=0", reqs); end
    total++; if (out_pixels_culled !== 16'd2) begin bad++; $display("FAIL offscreen_culled got=%0d exp=2", out_pixels_culled); end
    // (10,26) aliases the off-screen address 4170; depth 3 only passes if it was not written
    push_px(10, 26, 3, 16'h0ABC);
    wait_req(ok);
    total++; if (!ok || out_fb_addr !== 15'd4170 || out_fb_data !== 16'h0ABC) begin bad++; $display("FAIL offscreen_alias got=%b/%0d/%h exp=1/4170/0abc", ok, out_fb_addr, out_fb_data); end
    ack_once();
    total++; if (out_pixels_written !== 16'd3) begin bad++; $display("FAIL offscreen_written got=%0d exp=3", out_pixels_written); end
  endtask

  task automatic test_overflow();
    int reqs; bit ok;
    total++; if (out_sig_overflow !== 1'b0) begin bad++; $display("FAIL ovf_pre got=1 exp=0"); end
    push_px(0, 0, 2, 16'h1000);
    wait_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_first_req got=0 exp=1"); end
    for (int i = 1; i <= 5; i++) begin
      drive_px(i, 0, 2, 16'h1000 + i);
      @(negedge clock);
    end
    in_sig_write_pixel = 1'b0;
    total++; if (out_sig_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=0 exp=1"); end
    total++; if (out_sig_busy !== 1'b1) begin bad++; $display("FAIL ovf_busy got=0 exp=1"); end
    for (int k = 0; k < 5; k++) begin
      wait_req(ok);
      total++;
      if (!ok || out_fb_addr !== 15'(k) || out_fb_data !== 16'(16'h1000 + k)) begin
        bad++; $display("FAIL ovf_order k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, ok, out_fb_addr, out_fb_data, k, 16'h1000 + k);
      end
      ack_once();
    end
    watch(8, reqs);
    total++; if (reqs !== 0) begin bad++; $display("FAIL ovf_dropped got=%0d exp=0", reqs); end
    total++; if (out_pixels_written !== 16'd8) begin bad++; $display("FAIL ovf_written got=%0d exp=8", out_pixels_written); end
    total++; if (out_sig_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=0 exp=1"); end
  endtask

  task automatic test_frame_done();
    int pulses = 0, acks = 0; bit early = 1'b0;
    drive_px(20, 0, 1, 16'h2000);
    @(negedge clock);
    drive_px(21, 0, 1, 16'h2001);
    in_sig_rasterize_done = 1'b1;
    @(negedge clock);
    in_sig_write_pixel = 1'b0;
    in_sig_rasterize_done = 1'b0;
    total++; if (out_sig_frame_done !== 1'b0) begin bad++; $display("FAIL fd_early got=1 exp=0"); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (out_sig_frame_done) begin pulses++; if (acks < 2) early = 1'b1; end
      if (out_fb_write_req && !in_fb_write_ack) begin in_fb_write_ack = 1'b1; acks++; end
      else in_fb_write_ack = 1'b0;
    end
    in_fb_write_ack = 1'b0;
    total++; if (pulses !== 1) begin bad++; $display("FAIL fd_pulses got=%0d exp=1", pulses); end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL fd_before_ack got=1 exp=0"); end
    total++; if (acks !== 2 || out_pixels_written !== 16'd10) begin bad++; $display("FAIL fd_written got=%0d/%0d exp=2/10", acks, out_pixels_written); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    push_px(30, 0, 1, 16'h3000);
    wait_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_mid_req got=0 exp=1"); end
    reset = 1'b1;
    @(negedge clock);
    total++; if (out_fb_write_req !== 1'b0 || out_sig_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_ctrl got=%b/%b exp=0/0", out_fb_write_req, out_sig_busy); end
    total++; if ({out_pixels_written, out_pixels_culled} !== 32'd0) begin bad++; $display("FAIL rst_mid_counts got=%0d/%0d exp=0/0", out_pixels_written, out_pixels_culled); end
    total++; if ({out_sig_overflow, out_sig_frame_done} !== 2'b00 || out_fb_addr !== 15'd0 || out_fb_data !== 16'd0) begin bad++; $display("FAIL rst_mid_outs got=%b%b/%0d/%h exp=00/0/0", out_sig_overflow, out_sig_frame_done, out_fb_addr, out_fb_data); end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (out_fb_write_req !== 1'b0 || out_sig_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_after got=%b/%b exp=0/0", out_fb_write_req, out_sig_busy); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_basic();
    test_depth();
    test_offscreen();
    test_overflow();
    test_frame_done();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pixel_depth_writer.md
PIXEL_DEPTH_WRITER -- requirements
Module: pixel_depth_writer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, screen width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 120, screen height in pixels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, input pixel FIFO entries (power of two).
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous reset, active-high.
REQ-006 SHALL have ports in_sig_write_pixel  input  1  pixel strobe from the edge rasterizer; in_sig_rasterize_done  input  1  triangle-complete strobe from the edge rasterizer.
REQ-007 SHALL have ports in_pixel_x, in_pixel_y  input  16 each  screen coordinates; in_pixel_depth  input  2  depth, 0 = nearest; in_pixel_color  input  16  ARGB.
REQ-008 SHALL have port in_sig_clear_depth  input  1  request to reset the whole depth buffer to 3.
REQ-009 SHALL have ports out_fb_write_req  output  1; out_fb_addr  output  15; out_fb_data  output  16; in_fb_write_ack  input  1  framebuffer write handshake.
REQ-010 SHALL have ports out_sig_busy, out_sig_overflow, out_sig_frame_done  output  1 each; out_pixels_written, out_pixels_culled  output  16 each.

Function
REQ-011 SHALL hold an internal depth RAM of SCREEN_W*SCREEN_H 2-bit entries, address = y*SCREEN_W + x, one-cycle synchronous read.
REQ-012 SHALL push {x,y,depth,color} into the FIFO on a clock edge with in_sig_write_pixel=1 and FIFO not full, or full with a pop on the same edge.
REQ-013 SHALL drop a strobe arriving while full with no same-edge pop, and set out_sig_overflow sticky until reset.
REQ-014 SHALL implement FSM states IDLE, FETCH, TEST, WRITE, CLEAR.
REQ-015 IDLE: pending clear request -> CLEAR (priority); else FIFO non-empty -> pop, issue depth-RAM read, FETCH.
REQ-016 FETCH -> TEST unconditionally (read data valid in TEST).
REQ-017 TEST: x>=SCREEN_W or y>=SCREEN_H -> culled, IDLE, no RAM or framebuffer access; else in_depth <= stored depth -> WRITE; else culled -> IDLE.
REQ-018 WRITE: out_fb_write_req=1 with out_fb_addr/out_fb_data stable until the edge where in_fb_write_ack=1; on that edge write new depth to RAM, increment out_pixels_written, go to IDLE.
REQ-019 Latency: pixel pushed at edge N into empty FIFO with FSM idle -> popped edge N+1, TEST at N+2, out_fb_write_req high after edge N+3.
REQ-020 in_sig_clear_depth SHALL latch a request in any state; CLEAR writes 3 to addresses 0..SCREEN_W*SCREEN_H-1, one per cycle, then IDLE; the FIFO keeps accepting pushes during CLEAR.
REQ-021 out_pixels_culled SHALL increment once per culled pixel (depth fail or off-screen); both counters wrap at 16'hFFFF -> 0.
REQ-022 in_sig_rasterize_done SHALL set a sticky done flag; out_sig_frame_done pulses one cycle when flag set, FIFO empty, FSM IDLE, no clear pending; the pulse clears the flag.
REQ-023 out_sig_busy = 1 when FSM not IDLE or FIFO non-empty.
REQ-024 A second pixel to the same address SHALL see the depth written by the first (no read-before-write hazard).

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, empty FIFO, clear pending-clear and done flags, and zero every output, including out_fb_write_req mid-handshake.
REQ-026 Depth RAM contents SHALL NOT be reset; a clear request is required before first use.

Verification
REQ-027 Clear, then pixel (100,25,d=1,FF00) -> req after 3 cycles, addr 4100, data FF00; ack -> written=1.
REQ-028 Same address, d=2 after d=1 -> culled=1, no req; then d=0 -> written=2.
REQ-029 Pixel (170,25) -> culled, no req, no RAM write.
REQ-030 Hold ack low, push 5 pixels -> 4 accepted after first pops, overflow=1; release ack -> all queued written in order.
REQ-031 rasterize_done while 2 pixels queued -> frame_done pulses exactly once, after last ack.
REQ-032 reset during WRITE with req high -> req=0, busy=0, counters 0 next cycle.
